// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default bit period,
// used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned CLK_PER_BIT_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous line that idles high;
// both flops reset to 1 so reset never looks like a start bit.
module uart_sync2 (
  input  logic MasterClk,
  input  logic MasterRst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability filter: two back-to-back capture flops.
  always_ff @(posedge MasterClk or posedge MasterRst) begin
    if (MasterRst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronized line, mid-bit sampling, one-cycle
// data-valid / frame-error pulses and a held copy of the last good byte.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned Clk_per_bit = CLK_PER_BIT_DEF
) (
  input  logic       MasterClk,
  input  logic       MasterRst,
  input  logic       Serial_Data,
  output logic       rx_datavalid,
  output logic [7:0] Received_Byte,
  output logic       rx_active,
  output logic       rx_frame_error
);

  localparam logic [7:0] HALF_C = 8'((Clk_per_bit - 1) / 2);
  localparam logic [7:0] LAST_C = 8'(Clk_per_bit - 1);

  logic        rx_sync_s;
  uart_state_e state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [2:0]  idx_r, idx_s;
  logic [7:0]  shift_r, shift_s;
  logic [7:0]  byte_r, byte_s;
  logic        dv_r, dv_s;
  logic        fe_r, fe_s;
  logic        active_r, active_s;

  uart_sync2 u_sync (
    .MasterClk (MasterClk),
    .MasterRst (MasterRst),
    .d         (Serial_Data),
    .q         (rx_sync_s)
  );

  // Next-state and output decode; pulses default low so they last one cycle.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    idx_s    = idx_r;
    shift_s  = shift_r;
    byte_s   = byte_r;
    dv_s     = 1'b0;
    fe_s     = 1'b0;
    active_s = active_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s    = 8'd0;
        idx_s    = 3'd0;
        active_s = 1'b0;
        if (!rx_sync_s) begin
          state_s  = ST_START;
          active_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == HALF_C) begin
          cnt_s = 8'd0;
          if (!rx_sync_s) begin
            state_s = ST_DATA;
          end else begin
            // line went back high before mid-start: treat as a glitch
            state_s  = ST_IDLE;
            active_s = 1'b0;
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_DATA: begin
        if (cnt_r == LAST_C) begin
          cnt_s          = 8'd0;
          shift_s[idx_r] = rx_sync_s;
          if (idx_r == 3'd7) begin
            idx_s   = 3'd0;
            state_s = ST_STOP;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_STOP: begin
        if (cnt_r == LAST_C) begin
          cnt_s   = 8'd0;
          state_s = ST_CLEANUP;
          if (rx_sync_s) begin
            byte_s = shift_r;
            dv_s   = 1'b1;
          end else begin
            fe_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_CLEANUP: begin
        cnt_s    = 8'd0;
        active_s = 1'b0;
        state_s  = ST_IDLE;
      end
      default: begin
        cnt_s    = 8'd0;
        idx_s    = 3'd0;
        active_s = 1'b0;
        state_s  = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge MasterClk or posedge MasterRst) begin
    if (MasterRst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 8'd0;
      idx_r    <= 3'd0;
      shift_r  <= 8'h00;
      byte_r   <= 8'h00;
      dv_r     <= 1'b0;
      fe_r     <= 1'b0;
      active_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      shift_r  <= shift_s;
      byte_r   <= byte_s;
      dv_r     <= dv_s;
      fe_r     <= fe_s;
      active_r <= active_s;
    end
  end

  assign rx_datavalid   = dv_r;
  assign Received_Byte  = byte_r;
  assign rx_active      = active_r;
  assign rx_frame_error = fe_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized self-checking bench for uart_receiver: a behavioural 8N1 line
// driver plus an expected-frame table compared against every output pulse.
module tb_uart_receiver;

  localparam int CPB1 = 32;
  localparam int CPB2 = 16;
  // sync (2) + detect (1) + half start + 9 full bits + output register (1)
  localparam int LAT1 = 4 + (CPB1 - 1) / 2 + 9 * CPB1;

  logic       MasterClk = 1'b0;
  logic       MasterRst;
  logic       line1, line2;
  logic       dv1, fe1, act1, dv2, fe2, act2;
  logic [7:0] rb1, rb2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_b     [0:511];
  logic       exp_err   [0:511];
  int         exp_start [0:511];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] last_good = 8'h00;
  int         last_dv = 0;
  int         prev_dv = 0;

  logic [7:0] loop_exp [0:255];
  int         loop_rd = 0;
  int         seen [0:255];
  int         perm [0:255];

  uart_receiver #(.Clk_per_bit(CPB1)) u_dut (
    .MasterClk      (MasterClk),
    .MasterRst      (MasterRst),
    .Serial_Data    (line1),
    .rx_datavalid   (dv1),
    .Received_Byte  (rb1),
    .rx_active      (act1),
    .rx_frame_error (fe1)
  );

  uart_receiver #(.Clk_per_bit(CPB2)) u_dut16 (
    .MasterClk      (MasterClk),
    .MasterRst      (MasterRst),
    .Serial_Data    (line2),
    .rx_datavalid   (dv2),
    .Received_Byte  (rb2),
    .rx_active      (act2),
    .rx_frame_error (fe2)
  );

  always #5 MasterClk = ~MasterClk;

  always @(posedge MasterClk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge MasterClk);
      #1;
    end
  endtask

  // Drives one 8N1 frame; abort_bit >= 0 pulses reset halfway through that data bit.
  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop, input int abort_bit);
    int cpb;
    logic [9:0] fr;
    cpb = sel ? CPB2 : CPB1;
    fr  = {stop, b, 1'b0};
    if (!sel) begin
      exp_b[wr_ptr]     = b;
      exp_err[wr_ptr]   = ~stop;
      exp_start[wr_ptr] = cyc;
      wr_ptr++;
    end
    for (int i = 0; i < 10; i++) begin
      if (sel) line2 = fr[i];
      else     line1 = fr[i];
      if (abort_bit >= 0 && i == abort_bit + 1) begin
        tick(cpb / 2);
        MasterRst = 1'b1;
        tick(2);
        line1     = 1'b1;
        MasterRst = 1'b0;
        return;
      end
      tick(cpb);
    end
    if (sel) line2 = 1'b1;
    else     line1 = 1'b1;
  endtask

  // Scoreboard for the 32-cycle instance: every pulse must match the next expected frame.
  always @(negedge MasterClk) begin
    if (MasterRst) begin
      rd_ptr    <= wr_ptr;
      last_good <= 8'h00;
    end else if (dv1 || fe1) begin
      if (rd_ptr == wr_ptr) begin
        check_eq("spurious_pulse", {30'd0, dv1, fe1}, 32'd0);
      end else begin
        check_eq("pulse_kind", {30'd0, dv1, fe1}, exp_err[rd_ptr] ? 32'd1 : 32'd2);
        check_eq("pulse_latency", cyc - exp_start[rd_ptr], LAT1);
        check_eq("rx_byte", {24'd0, rb1}, {24'd0, exp_err[rd_ptr] ? last_good : exp_b[rd_ptr]});
        if (!exp_err[rd_ptr]) last_good <= exp_b[rd_ptr];
        if (dv1) begin
          prev_dv <= last_dv;
          last_dv <= cyc;
        end
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  // Loopback scoreboard for the 16-cycle instance.
  always @(negedge MasterClk) begin
    if (!MasterRst && (dv2 || fe2)) begin
      check_eq("loop_fe", {31'd0, fe2}, 32'd0);
      check_eq("loop_byte", {24'd0, rb2}, {24'd0, loop_exp[loop_rd[7:0]]});
      seen[rb2] <= seen[rb2] + 1;
      loop_rd   <= loop_rd + 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit         rose, fell;
    logic [7:0] b;
    bit         err;
    int         j, tmp;

    for (int i = 0; i < 256; i++) seen[i] = 0;
    MasterRst = 1'b1;
    line1     = 1'b1;
    line2     = 1'b1;
    tick(3);
    check_eq("rst_byte", {24'd0, rb1}, 32'h00);
    check_eq("rst_pulses", {30'd0, dv1, fe1}, 32'd0);
    check_eq("rst_active", {31'd0, act1}, 32'd0);
    MasterRst = 1'b0;
    tick(5);

    // good frame
    send_frame(1'b0, 8'hA5, 1'b1, -1);
    tick(20);
    check_eq("a5_byte", {24'd0, rb1}, 32'hA5);
    check_eq("a5_pending", wr_ptr - rd_ptr, 32'd0);

    // 10-cycle low glitch on an idle line
    line1 = 1'b0;
    rose  = 1'b0;
    fell  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) line1 = 1'b1;
      tick(1);
      if (act1) rose = 1'b1;
      else if (rose && !fell && i <= 24) fell = 1'b1;
    end
    check_eq("glitch_rose", {31'd0, rose}, 32'd1);
    check_eq("glitch_fell", {31'd0, fell}, 32'd1);
    check_eq("glitch_byte", {24'd0, rb1}, 32'hA5);

    // stop bit forced low
    send_frame(1'b0, 8'h3C, 1'b0, -1);
    tick(80);
    check_eq("ferr_byte", {24'd0, rb1}, 32'hA5);
    check_eq("ferr_pending", wr_ptr - rd_ptr, 32'd0);

    // back-to-back frames, no idle gap
    send_frame(1'b0, 8'h00, 1'b1, -1);
    send_frame(1'b0, 8'hFF, 1'b1, -1);
    tick(20);
    check_eq("b2b_spacing", last_dv - prev_dv, 10 * CPB1);
    check_eq("b2b_byte", {24'd0, rb1}, 32'hFF);
    check_eq("b2b_pending", wr_ptr - rd_ptr, 32'd0);

    // reset during data bit 4, then a fresh frame
    send_frame(1'b0, 8'h55, 1'b1, 4);
    tick(3);
    check_eq("abort_byte", {24'd0, rb1}, 32'h00);
    check_eq("abort_active", {31'd0, act1}, 32'd0);
    tick(40);
    check_eq("abort_byte_held", {24'd0, rb1}, 32'h00);
    send_frame(1'b0, 8'h81, 1'b1, -1);
    tick(20);
    check_eq("after_abort_byte", {24'd0, rb1}, 32'h81);
    check_eq("after_abort_pending", wr_ptr - rd_ptr, 32'd0);

    // random frames, occasional bad stop bit, random idle gaps
    repeat (24) begin
      b   = 8'($urandom);
      err = ($urandom_range(0, 7) == 0);
      send_frame(1'b0, b, ~err, -1);
      tick(err ? 80 : int'($urandom_range(0, 40)));
    end
    tick(20);
    check_eq("rand_pending", wr_ptr - rd_ptr, 32'd0);
    check_eq("rand_hold", {24'd0, rb1}, {24'd0, last_good});

    // loopback of all 256 values in shuffled order at 16 cycles per bit
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j       = int'($urandom_range(0, i));
      tmp     = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int k = 0; k < 256; k++) begin
      loop_exp[k] = 8'(perm[k]);
      send_frame(1'b1, 8'(perm[k]), 1'b1, -1);
    end
    tick(40);
    check_eq("loop_count", loop_rd, 32'd256);
    for (int v = 0; v < 256; v++) check_eq("loop_seen", seen[v], 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
